// File: rtl/jk_excite_driver.sv
// Steers an external JK flop bank from q_in to a requested word using the JK excitation table (never J=K=1).
// Optional macro JK_PARALLEL_EN: drive every differing bit per step instead of one bit per step.
module jk_excite_driver #(
  parameter int WIDTH      = 4,
  parameter int STEP_LIMIT = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(STEP_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] diff, sel;
  logic [WIDTH-1:0] j_nxt, k_nxt;
  logic [CNT_W-1:0] step_cnt, step_cnt_nxt;
  logic             busy_nxt, done_nxt, err_nxt;
  logic             accept;

  function automatic logic [WIDTH-1:0] lowest_set(input logic [WIDTH-1:0] v);
    return v & (~v + WIDTH'(1));
  endfunction

  assign tgt_ready = (state == IDLE);
  assign accept    = tgt_valid && tgt_ready;
  assign diff      = tgt_r ^ q_in;

`ifdef JK_PARALLEL_EN
  assign sel = diff;
`else
  assign sel = lowest_set(diff);
`endif

  always_comb begin
    state_nxt    = state;
    step_cnt_nxt = step_cnt;
    j_nxt        = '0;
    k_nxt        = '0;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    err_nxt      = err;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt    = DRIVE;
          step_cnt_nxt = '0;
          err_nxt      = 1'b0;
          busy_nxt     = 1'b1;
        end
      end
      DRIVE: begin
        if (diff == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else if (step_cnt == CNT_W'(STEP_LIMIT)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          // Set-to-1 bits get J, clear-to-0 bits get K, so J&K is structurally zero.
          j_nxt        = sel & tgt_r;
          k_nxt        = sel & ~tgt_r;
          step_cnt_nxt = step_cnt + CNT_W'(1);
          state_nxt    = WAIT;
        end
      end
      WAIT:    state_nxt = DRIVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      step_cnt <= '0;
      j        <= '0;
      k        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_cnt_nxt;
      j        <= j_nxt;
      k        <= k_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

  // Target word is datapath only; it is qualified by state and needs no reset.
  always_ff @(posedge clk) begin
    if (accept) tgt_r <= tgt_data;
  end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Scoreboarded bench for jk_excite_driver with an ideal (optionally stuck-at-0) JK bank on q_in.
module tb_jk_excite_driver;
  localparam int WIDTH      = 4;
  localparam int STEP_LIMIT = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic             tgt_valid;
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_ready;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] j, k;
  logic             busy, done, err;

  logic             bank_load;
  logic [WIDTH-1:0] bank_load_val;
  logic [WIDTH-1:0] stuck_mask;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int               lat;
    logic             err;
    logic [WIDTH-1:0] tgt;
    int               acc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  jk_excite_driver #(.WIDTH(WIDTH), .STEP_LIMIT(STEP_LIMIT)) dut (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
    .tgt_ready(tgt_ready), .q_in(q_in), .j(j), .k(k),
    .busy(busy), .done(done), .err(err)
  );

  // Ideal JK bank: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits.
  always @(posedge clk) begin
    if (bank_load) q_in <= bank_load_val & ~stuck_mask;
    else           q_in <= ((j & ~q_in) | (~k & q_in)) & ~stuck_mask;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Outcome from the transfer rules: each differing bit costs one DRIVE/WAIT pair (all at
  // once in parallel mode); a target bit that the bank cannot reach ends in a timeout.
  function automatic exp_t ref_model(input logic [WIDTH-1:0] q0, input logic [WIDTH-1:0] tgt,
                                     input logic [WIDTH-1:0] stuck, input int acc);
    exp_t r;
    logic [WIDTH-1:0] need;
    need  = q0 ^ tgt;
    r.tgt = tgt;
    r.acc = acc;
    r.err = 1'b0;
    if ((tgt & stuck) != '0) begin
      r.err = 1'b1;
      r.lat = 2 * STEP_LIMIT + 1;
    end else if (need == '0) begin
      r.lat = 1;
    end else begin
`ifdef JK_PARALLEL_EN
      r.lat = 3;
`else
      r.lat = 2 * $countones(need) + 1;
`endif
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
    end else begin
      check("jk_excl", int'(|(j & k)), 0);
      check("ready_vs_busy", int'(tgt_ready), int'(!busy));
      if (busy && sb.size() > 0) begin
        check("j_dir", int'(|(j & ~sb[0].tgt)), 0);
        check("k_dir", int'(|(k & sb[0].tgt)), 0);
        check("err_clr", int'(err), 0);
`ifndef JK_PARALLEL_EN
        check("one_bit", int'($countones(j | k) <= 1), 1);
`endif
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending transfer");
        end else begin
          e = sb.pop_front();
          check("latency", cyc - e.acc, e.lat);
          check("err", int'(err), int'(e.err));
          check("busy_at_done", int'(busy), 0);
          if (!e.err) check("q_final", int'(q_in), int'(e.tgt));
        end
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] t);
    int guard = 0;
    logic [WIDTH-1:0] q0;
    @(negedge clk);
    while (!tgt_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!tgt_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got tgt_ready=0 expected 1 within 200 cycles");
      return;
    end
    tgt_valid = 1'b1;
    tgt_data  = t;
    q0        = q_in;
    @(posedge clk);
    #1;
    sb.push_back(ref_model(q0, t, stuck_mask, cyc));
    tgt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    @(negedge clk);
    bank_load     = 1'b1;
    bank_load_val = v;
    @(posedge clk);
    #1;
    bank_load = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    tgt_valid  = 1'b0;
    tgt_data   = '0;
    bank_load  = 1'b0;
    bank_load_val = '0;
    stuck_mask = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_j", int'(j), 0);
    check("rst_k", int'(k), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_ready", int'(tgt_ready), 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed cases
    load(4'b0000); send(4'b0101); wait_idle();
    load(4'b0110); send(4'b0110); wait_idle();
    load(4'b1111); send(4'b0000); wait_idle();
    stuck_mask = 4'b0100;
    load(4'b0000); send(4'b0100); wait_idle();
    stuck_mask = 4'b0000;
    send(4'b0001); wait_idle();
    load(4'b1010); send(4'b0101); wait_idle();

    // Asynchronous reset in WAIT
    load(4'b0000); send(4'b0010);
    @(posedge clk);
    #2;
    check("pre_reset_j", int'(j), 2);
    reset = 1'b1;
    #1;
    check("arst_j", int'(j), 0);
    check("arst_k", int'(k), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_err", int'(err), 0);
    check("arst_ready", int'(tgt_ready), 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    load(4'b1001); send(4'b0110); wait_idle();

    // Randomized transfers, mostly back-to-back
    for (int i = 0; i < 60; i++) begin
      if (i % 4 == 0) begin
        wait_idle();
        stuck_mask = ($urandom_range(0, 5) == 0) ? WIDTH'(1 << $urandom_range(0, WIDTH - 1)) : '0;
        load(WIDTH'($urandom));
      end
      send(WIDTH'($urandom));
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
